// File: rtl/hazard_sequencer_if.sv
// IF/ID sequencing bus: fetch data, ID-stage fields, EX hazard info and the
// stall/flush controls returned to the pipeline.
interface hazard_sequencer_if;
    logic [31:0] imem_data;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;
    logic        pc_en;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        idex_bubble;
    logic        md_busy;

    modport master (
        output imem_data, id_opcode, id_funct, id_rs, id_rt,
               ex_mem_read, ex_rt, ex_branch_taken,
        input  pc_en, ifid_instr, ifid_valid, idex_bubble, md_busy
    );

    modport slave (
        input  imem_data, id_opcode, id_funct, id_rs, id_rt,
               ex_mem_read, ex_rt, ex_branch_taken,
        output pc_en, ifid_instr, ifid_valid, idex_bubble, md_busy
    );
endinterface

// File: rtl/hazard_sequencer.sv
// IF/ID sequencing controller: owns the IF/ID register and resolves branch
// flushes, load-use stalls, MULT/DIV occupancy stalls and jump kills.
module hazard_sequencer #(
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    hazard_sequencer_if.slave bus
);
    localparam int CW = $clog2(MD_LAT + 1);

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] md_cnt, md_cnt_nxt;
    logic [31:0]   instr_q, instr_nxt;
    logic          valid_q, valid_nxt;

    logic is_special, jump, md_op, hilo_use, load_use, md_stall, issue;
    logic pc_en, bubble;

    always_comb begin
        is_special = (bus.id_opcode == 6'h00);
        jump       = valid_q & ((bus.id_opcode == 6'h02) | (bus.id_opcode == 6'h03) |
                                (is_special & (bus.id_funct == 6'h08)));
        md_op      = valid_q & is_special & (bus.id_funct[5:2] == 4'b0110);
        hilo_use   = md_op | (valid_q & is_special &
                              ((bus.id_funct == 6'h10) | (bus.id_funct == 6'h12)));
        load_use   = valid_q & bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                     ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));
        md_stall   = (state == MD_BUSY) & hilo_use;
    end

    // Priority: taken branch > load-use > MD stall > jump > normal advance.
    always_comb begin
        pc_en     = 1'b1;
        bubble    = 1'b0;
        instr_nxt = bus.imem_data;
        valid_nxt = 1'b1;
        if (bus.ex_branch_taken) begin
            bubble    = 1'b1;
            instr_nxt = 32'd0;
            valid_nxt = 1'b0;
        end else if (load_use || md_stall) begin
            pc_en     = 1'b0;
            bubble    = 1'b1;
            instr_nxt = instr_q;
            valid_nxt = valid_q;
        end else if (jump) begin
            instr_nxt = 32'd0;
            valid_nxt = 1'b0;
        end
    end

    // An MD op issues only when it leaves ID, i.e. not flushed or stalled.
    assign issue = ~bus.ex_branch_taken & ~load_use & ~md_stall;

    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        case (state)
            RUN: begin
                if (md_op && issue) begin
                    state_nxt  = MD_BUSY;
                    md_cnt_nxt = CW'(MD_LAT);
                end
            end
            MD_BUSY: begin
                if (md_cnt == CW'(1)) begin
                    state_nxt  = RUN;
                    md_cnt_nxt = '0;
                end else begin
                    md_cnt_nxt = md_cnt - CW'(1);
                end
            end
            default: begin
                state_nxt  = RUN;
                md_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            md_cnt  <= '0;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            md_cnt  <= md_cnt_nxt;
            instr_q <= instr_nxt;
            valid_q <= valid_nxt;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.idex_bubble = bubble;
    assign bus.ifid_instr  = instr_q;
    assign bus.ifid_valid  = valid_q;
    assign bus.md_busy     = (state == MD_BUSY);
endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: per-cycle comparison against an
// abstract pipeline model plus hand-computed spot checks.
module tb_hazard_sequencer;
    localparam int MD_LAT = 4;

    localparam logic [31:0] LW   = 32'h8C220004; // lw   $2,4($1)
    localparam logic [31:0] ADD  = 32'h00441820; // add  $3,$2,$4
    localparam logic [31:0] ADD2 = 32'h012A4020; // add  $8,$9,$10
    localparam logic [31:0] ADDI = 32'h20030005; // addi $3,$0,5
    localparam logic [31:0] JMP  = 32'h08000010; // j
    localparam logic [31:0] JR   = 32'h03E00008; // jr   $31
    localparam logic [31:0] MULT = 32'h00A60018; // mult $5,$6
    localparam logic [31:0] MFLO = 32'h00003812; // mflo $7

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    hazard_sequencer_if bus ();

    hazard_sequencer #(.MD_LAT(MD_LAT)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    // Field splitter downstream of ifid_instr.
    assign bus.id_opcode = bus.ifid_instr[31:26];
    assign bus.id_rs     = bus.ifid_instr[25:21];
    assign bus.id_rt     = bus.ifid_instr[20:16];
    assign bus.id_funct  = bus.ifid_instr[5:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what sits in IF/ID and how many MD cycles remain.
    logic [31:0] m_instr;
    logic        m_valid;
    int          m_left;

    always @(negedge clk) begin
        logic [5:0] op, fn;
        logic [4:0] rs, rt;
        logic       j, md, hilo, lu, ms, e_pc, e_bub;
        if (!rst_n) begin
            m_instr = 32'd0;
            m_valid = 1'b0;
            m_left  = 0;
            chk("m_rst_instr", bus.ifid_instr, 32'd0);
            chk("m_rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
            chk("m_rst_busy", {31'd0, bus.md_busy}, 32'd0);
        end else begin
            op   = m_instr[31:26];
            rs   = m_instr[25:21];
            rt   = m_instr[20:16];
            fn   = m_instr[5:0];
            j    = m_valid && (op == 6'h02 || op == 6'h03 || (op == 6'h00 && fn == 6'h08));
            md   = m_valid && op == 6'h00 && (fn == 6'h18 || fn == 6'h19 || fn == 6'h1A || fn == 6'h1B);
            hilo = md || (m_valid && op == 6'h00 && (fn == 6'h10 || fn == 6'h12));
            lu   = m_valid && bus.ex_mem_read && bus.ex_rt != 0 && (bus.ex_rt == rs || bus.ex_rt == rt);
            ms   = (m_left > 0) && hilo;
            e_pc  = !(!bus.ex_branch_taken && (lu || ms));
            e_bub = bus.ex_branch_taken || lu || ms;
            chk("m_pc_en", {31'd0, bus.pc_en}, {31'd0, e_pc});
            chk("m_bubble", {31'd0, bus.idex_bubble}, {31'd0, e_bub});
            chk("m_instr", bus.ifid_instr, m_instr);
            chk("m_valid", {31'd0, bus.ifid_valid}, {31'd0, m_valid});
            chk("m_busy", {31'd0, bus.md_busy}, {31'd0, m_left > 0});
            if (m_left > 0)
                m_left = m_left - 1;
            else if (md && !bus.ex_branch_taken && !lu)
                m_left = MD_LAT;
            if (bus.ex_branch_taken || (!lu && !ms && j)) begin
                m_instr = 32'd0;
                m_valid = 1'b0;
            end else if (!lu && !ms) begin
                m_instr = bus.imem_data;
                m_valid = 1'b1;
            end
        end
    end

    task automatic drive(input logic [31:0] im, input logic mr, input logic [4:0] er, input logic br);
        bus.imem_data       = im;
        bus.ex_mem_read     = mr;
        bus.ex_rt           = er;
        bus.ex_branch_taken = br;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(32'd0, 1'b0, 5'd0, 1'b0);
        tick(); tick();
        chk("rst_pc_en", {31'd0, bus.pc_en}, 32'd1);
        chk("rst_bubble", {31'd0, bus.idex_bubble}, 32'd0);
        chk("rst_md_busy", {31'd0, bus.md_busy}, 32'd0);

        rst_n = 1'b1;
        drive(LW, 1'b0, 5'd0, 1'b0);
        tick();
        chk("lw_in_id", bus.ifid_instr, LW);
        rst_n = 1'b0;
        #1;
        chk("async_rst_instr", bus.ifid_instr, 32'd0);
        chk("async_rst_valid", {31'd0, bus.ifid_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_pc_en", {31'd0, bus.pc_en}, 32'd1);
        chk("post_rst_md_busy", {31'd0, bus.md_busy}, 32'd0);

        // Load-use on rs, then clean advance, then ex_rt=0, then match on rt.
        drive(ADD, 1'b0, 5'd0, 1'b0); tick();
        drive(ADD2, 1'b1, 5'd2, 1'b0);
        chk("lu_pc_en", {31'd0, bus.pc_en}, 32'd0);
        chk("lu_bubble", {31'd0, bus.idex_bubble}, 32'd1);
        tick();
        chk("lu_hold", bus.ifid_instr, ADD);
        drive(ADD2, 1'b0, 5'd0, 1'b0);
        chk("lu_release_pc_en", {31'd0, bus.pc_en}, 32'd1);
        chk("lu_release_bubble", {31'd0, bus.idex_bubble}, 32'd0);
        tick();
        chk("lu_advance", bus.ifid_instr, ADD2);
        drive(ADDI, 1'b0, 5'd0, 1'b0); tick();
        drive(ADD, 1'b1, 5'd0, 1'b0);
        chk("rt0_pc_en", {31'd0, bus.pc_en}, 32'd1);
        chk("rt0_bubble", {31'd0, bus.idex_bubble}, 32'd0);
        tick();
        drive(ADD2, 1'b1, 5'd4, 1'b0);
        chk("lu_rt_pc_en", {31'd0, bus.pc_en}, 32'd0);
        tick();
        chk("lu_rt_hold", bus.ifid_instr, ADD);

        // Branch wins over a live load-use.
        drive(ADD2, 1'b1, 5'd4, 1'b1);
        chk("br_pc_en", {31'd0, bus.pc_en}, 32'd1);
        chk("br_bubble", {31'd0, bus.idex_bubble}, 32'd1);
        tick();
        chk("br_flush_instr", bus.ifid_instr, 32'd0);
        chk("br_flush_valid", {31'd0, bus.ifid_valid}, 32'd0);

        // j and jr kill the fall-through fetch.
        drive(JMP, 1'b0, 5'd0, 1'b0); tick();
        drive(ADD, 1'b0, 5'd0, 1'b0);
        chk("j_pc_en", {31'd0, bus.pc_en}, 32'd1);
        chk("j_bubble", {31'd0, bus.idex_bubble}, 32'd0);
        tick();
        chk("j_kill_valid", {31'd0, bus.ifid_valid}, 32'd0);
        drive(JR, 1'b0, 5'd0, 1'b0); tick();
        drive(ADD, 1'b0, 5'd0, 1'b0);
        chk("jr_pc_en", {31'd0, bus.pc_en}, 32'd1);
        chk("jr_bubble", {31'd0, bus.idex_bubble}, 32'd0);
        tick();
        chk("jr_kill_valid", {31'd0, bus.ifid_valid}, 32'd0);

        // mult; add; mflo -> add flows, mflo held 3 cycles.
        drive(MULT, 1'b0, 5'd0, 1'b0); tick();
        drive(ADD2, 1'b0, 5'd0, 1'b0);
        chk("mult_issue_busy", {31'd0, bus.md_busy}, 32'd0);
        tick();
        chk("md_busy_set", {31'd0, bus.md_busy}, 32'd1);
        drive(MFLO, 1'b0, 5'd0, 1'b0);
        chk("md_add_bubble", {31'd0, bus.idex_bubble}, 32'd0);
        tick();
        drive(ADD, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("mflo_hold_bubble", {31'd0, bus.idex_bubble}, 32'd1);
            chk("mflo_hold_busy", {31'd0, bus.md_busy}, 32'd1);
            tick();
        end
        chk("mflo_issue_busy", {31'd0, bus.md_busy}, 32'd0);
        chk("mflo_issue_bubble", {31'd0, bus.idex_bubble}, 32'd0);
        chk("mflo_issue_instr", bus.ifid_instr, MFLO);
        tick();
        chk("after_mflo", bus.ifid_instr, ADD);

        // Branch while md_cnt=2: flush, occupancy continues on schedule.
        drive(MULT, 1'b0, 5'd0, 1'b0); tick();
        drive(MFLO, 1'b0, 5'd0, 1'b0); tick();
        drive(ADD, 1'b0, 5'd0, 1'b0); tick(); tick();
        drive(ADD, 1'b0, 5'd0, 1'b1);
        chk("mdbr_pc_en", {31'd0, bus.pc_en}, 32'd1);
        chk("mdbr_bubble", {31'd0, bus.idex_bubble}, 32'd1);
        tick();
        drive(ADD2, 1'b0, 5'd0, 1'b0);
        chk("mdbr_busy_cnt1", {31'd0, bus.md_busy}, 32'd1);
        chk("mdbr_flushed", {31'd0, bus.ifid_valid}, 32'd0);
        tick();
        chk("mdbr_busy_drop", {31'd0, bus.md_busy}, 32'd0);

        drive(32'd0, 1'b0, 5'd0, 1'b0);
        tick(); tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
